// File: rtl/branch_target_predictor_if.sv
// rtl/branch_target_predictor_if.sv - fetch/execute side bus of the branch target predictor
interface branch_target_predictor_if #(
   parameter int PC_W  = 9,
   parameter int CNT_W = 16
);
   logic             lookup_valid;
   logic [PC_W-1:0]  lookup_pc;
   logic             pred_valid;
   logic             pred_hit;
   logic             pred_taken;
   logic [PC_W-1:0]  pred_target;
   logic             update_valid;
   logic [PC_W-1:0]  update_pc;
   logic             update_is_jump;
   logic             update_taken;
   logic [PC_W-1:0]  update_target;
   logic             update_mispredict;
   logic             inv_all;
   logic [CNT_W-1:0] mispredict_cnt;

   modport master (
      output lookup_valid, lookup_pc,
      output update_valid, update_pc, update_is_jump, update_taken, update_target, update_mispredict,
      output inv_all,
      input  pred_valid, pred_hit, pred_taken, pred_target, mispredict_cnt
   );

   modport slave (
      input  lookup_valid, lookup_pc,
      input  update_valid, update_pc, update_is_jump, update_taken, update_target, update_mispredict,
      input  inv_all,
      output pred_valid, pred_hit, pred_taken, pred_target, mispredict_cnt
   );
endinterface

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped BTB with 2-bit counters, looked up in IF, trained from EX
module branch_target_predictor #(
   parameter int PC_W    = 9,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 16
) (
   input logic                    clk,
   input logic                    reset,
   branch_target_predictor_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - 2 - IDX_W;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [ENTRIES-1:0] jump_q, jump_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [PC_W-1:0]    target_q [ENTRIES];
   logic [PC_W-1:0]    target_d [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];

   logic               pred_valid_q, pred_valid_d;
   logic               pred_hit_q, pred_hit_d;
   logic               pred_taken_q, pred_taken_d;
   logic [PC_W-1:0]    pred_target_q, pred_target_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [IDX_W-1:0]   lk_idx, up_idx;
   logic [TAG_W-1:0]   lk_tag, up_tag;
   logic               lk_hit, lk_taken, up_hit;
   logic [PC_W-1:0]    lk_target;
   logic               unused_pc_bits;

   assign unused_pc_bits = ^bus.update_pc[1:0];

   assign lk_idx    = bus.lookup_pc[IDX_W+1:2];
   assign lk_tag    = bus.lookup_pc[PC_W-1:IDX_W+2];
   assign up_idx    = bus.update_pc[IDX_W+1:2];
   assign up_tag    = bus.update_pc[PC_W-1:IDX_W+2];

   // Lookup reads the registered table, so same-edge updates are not yet visible.
   assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign lk_taken  = lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][1]);
   assign lk_target = lk_taken ? target_q[lk_idx] : bus.lookup_pc + PC_W'(4);
   assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

   always_comb begin
      pred_valid_d  = bus.lookup_valid;
      pred_hit_d    = pred_hit_q;
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
      if (bus.lookup_valid) begin
         pred_hit_d    = lk_hit;
         pred_taken_d  = lk_taken;
         pred_target_d = lk_target;
      end
   end

   always_comb begin
      valid_d  = valid_q;
      jump_d   = jump_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (bus.inv_all) begin
         valid_d = '0;
      end else if (bus.update_valid) begin
         if (up_hit) begin
            if (bus.update_is_jump) begin
               target_d[up_idx] = bus.update_target;
               jump_d[up_idx]   = 1'b1;
               ctr_d[up_idx]    = 2'b11;
            end else begin
               jump_d[up_idx] = 1'b0;
               if (bus.update_taken) begin
                  target_d[up_idx] = bus.update_target;
                  if (ctr_q[up_idx] != 2'b11) ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
               end else if (ctr_q[up_idx] != 2'b00) begin
                  ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
               end
            end
         end else if (bus.update_taken) begin
            // Allocation evicts whatever aliases onto this index.
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = bus.update_target;
            jump_d[up_idx]   = bus.update_is_jump;
            ctr_d[up_idx]    = bus.update_is_jump ? 2'b11 : 2'b10;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (bus.update_valid && bus.update_mispredict && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q       <= '0;
         jump_q        <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
         pred_valid_q  <= 1'b0;
         pred_hit_q    <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
         cnt_q         <= '0;
      end else begin
         valid_q       <= valid_d;
         jump_q        <= jump_d;
         tag_q         <= tag_d;
         target_q      <= target_d;
         ctr_q         <= ctr_d;
         pred_valid_q  <= pred_valid_d;
         pred_hit_q    <= pred_hit_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
         cnt_q         <= cnt_d;
      end
   end

   assign bus.pred_valid     = pred_valid_q;
   assign bus.pred_hit       = pred_hit_q;
   assign bus.pred_taken     = pred_taken_q;
   assign bus.pred_target    = pred_target_q;
   assign bus.mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb/tb_branch_target_predictor.sv - scoreboard bench with a behavioural BTB model
module tb_branch_target_predictor;
   localparam int PC_W    = 9;
   localparam int ENTRIES = 16;
   localparam int CNT_W   = 4;
   localparam int PC_MOD  = 1 << PC_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int IDX_DIV = 4 * ENTRIES;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   branch_target_predictor_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

   branch_target_predictor #(.PC_W(PC_W), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct { bit v; int tag; int tgt; bit jmp; int ctr; } ent_t;
   typedef struct { bit hit; bit taken; int tgt; } exp_t;

   ent_t m [ENTRIES];
   int   m_cnt;
   exp_t q [$];
   int   total = 0;
   int   bad   = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock: drive, predict the lookup from the pre-edge model, then advance the model.
   task automatic cyc(input bit lv, input int lpc, input bit uv, input int upc, input bit uj,
                      input bit ut, input int utgt, input bit um, input bit inv, input bit rst);
      int i, t;
      bit h;
      exp_t e;
      reset                 = rst;
      bus.lookup_valid      = lv;
      bus.lookup_pc         = PC_W'(lpc);
      bus.update_valid      = uv;
      bus.update_pc         = PC_W'(upc);
      bus.update_is_jump    = uj;
      bus.update_taken      = ut;
      bus.update_target     = PC_W'(utgt);
      bus.update_mispredict = um;
      bus.inv_all           = inv;
      if (!rst && lv) begin
         i = (lpc / 4) % ENTRIES;
         t = lpc / IDX_DIV;
         e.hit   = m[i].v && (m[i].tag == t);
         e.taken = e.hit && (m[i].jmp || m[i].ctr >= 2);
         e.tgt   = e.taken ? m[i].tgt : (lpc + 4) % PC_MOD;
         q.push_back(e);
      end
      @(posedge clk);
      if (rst) begin
         foreach (m[k]) begin m[k].v = 0; m[k].ctr = 1; end
         m_cnt = 0;
      end else begin
         if (uv && um && m_cnt < CNT_MAX) m_cnt++;
         if (inv) begin
            foreach (m[k]) m[k].v = 0;
         end else if (uv) begin
            i = (upc / 4) % ENTRIES;
            t = upc / IDX_DIV;
            h = m[i].v && (m[i].tag == t);
            if (h && uj) begin
               m[i].tgt = utgt; m[i].jmp = 1; m[i].ctr = 3;
            end else if (h) begin
               m[i].jmp = 0;
               if (ut) begin m[i].tgt = utgt; m[i].ctr = (m[i].ctr == 3) ? 3 : m[i].ctr + 1; end
               else m[i].ctr = (m[i].ctr == 0) ? 0 : m[i].ctr - 1;
            end else if (ut) begin
               m[i].v = 1; m[i].tag = t; m[i].tgt = utgt; m[i].jmp = uj; m[i].ctr = uj ? 3 : 2;
            end
         end
      end
      #1;
   endtask

   task automatic look(input int pc);
      cyc(1, pc, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic upd(input int pc, input bit j, input bit t, input int tgt, input bit mis);
      cyc(0, 0, 1, pc, j, t, tgt, mis, 0, 0);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.pred_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_pred_valid", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("pred_hit", int'(bus.pred_hit), int'(e.hit));
               chk("pred_taken", int'(bus.pred_taken), int'(e.taken));
               chk("pred_target", int'(bus.pred_target), e.tgt);
            end
         end
         chk("mispredict_cnt", int'(bus.mispredict_cnt), m_cnt);
      end
   end

   initial begin
      int lpc, upc;
      bit inv, um;
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(1, 'h10, 1, 'h10, 0, 1, 'h40, 1, 0, 1);
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_pred_valid", int'(bus.pred_valid), 0);
      chk("rst_pred_hit", int'(bus.pred_hit), 0);
      chk("rst_pred_taken", int'(bus.pred_taken), 0);
      chk("rst_pred_target", int'(bus.pred_target), 0);
      chk("rst_cnt", int'(bus.mispredict_cnt), 0);

      look('h010);
      upd('h010, 0, 1, 'h040, 1);
      look('h010);
      upd('h010, 0, 0, 0, 0);
      upd('h010, 0, 0, 0, 0);
      look('h010);
      repeat (3) upd('h010, 0, 1, 'h040, 0);
      upd('h010, 0, 0, 0, 1);
      look('h010);
      look('h050);
      upd('h050, 1, 1, 'h100, 0);
      look('h050);
      look('h010);

      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      look('h1FC);
      upd('h020, 0, 0, 'h0AC, 0);
      look('h020);
      cyc(1, 'h030, 1, 'h030, 0, 1, 'h080, 0, 0, 0);
      look('h030);
      upd('h070, 1, 1, 'h1F0, 0);
      cyc(0, 0, 1, 'h0B0, 0, 1, 'h0C0, 0, 1, 0);
      look('h070);
      look('h0B0);
      look('h030);

      repeat (20) upd('h024, 0, 0, 0, 1);
      @(negedge clk);
      chk("cnt_saturated", int'(bus.mispredict_cnt), CNT_MAX);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("cnt_after_inv", int'(bus.mispredict_cnt), CNT_MAX);
      look('h010);
      cyc(1, 'h010, 1, 'h010, 0, 1, 'h040, 1, 0, 1);
      @(negedge clk);
      chk("mid_reset_pred_valid", int'(bus.pred_valid), 0);
      chk("mid_reset_cnt", int'(bus.mispredict_cnt), 0);

      for (int n = 0; n < 3000; n++) begin
         lpc = ($urandom_range(0, 1) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) lpc = $urandom_range(0, PC_MOD - 1);
         upc = ($urandom_range(0, 1) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) upc = lpc;
         inv = ($urandom_range(0, 63) == 0);
         um  = !inv && ($urandom_range(0, 3) == 0);
         cyc($urandom_range(0, 3) != 0, lpc, $urandom_range(0, 1) == 1, upc,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, PC_MOD - 1), um, inv, $urandom_range(0, 255) == 0);
      end

      idle();
      idle();
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
